// File: rtl/key_pkg.sv
// key_pkg
//   Shared definitions for the push-button blocks: the press-classifier state
//   encoding and the default timing constants for a 50 MHz clock. Sibling key
//   and display blocks import this package so they agree on both.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HELD       = 3'd2,
        ST_LONG_HELD  = 3'd3,
        ST_DB_RELEASE = 3'd4
    } key_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;   // 20 ms
    localparam int unsigned DEF_LONG_CYCLES     = 32'd50000000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES   = 32'd10000000;  // 200 ms

    localparam int CNT_W = 32;

endpackage

// File: rtl/key_sync.sv
// key_sync
//   Two-stage synchronizer bringing an asynchronous level into the clk domain.
//   Both stages load RESET_VAL while rstn is low.
// Ports
//   clk   in   clock
//   rstn  in   synchronous active-low reset
//   d     in   asynchronous input level
//   q     out  synchronized level (two clk edges of latency)
module key_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_press_classifier.sv
// key_press_classifier
//   Debounces an active-low push-button and classifies each press as short,
//   long, or long with auto-repeat. One instance per board key; instances are
//   independent and drive the downstream counter/LED logic through the pulses.
// Ports
//   clk           in   single clock
//   rstn          in   synchronous active-low reset
//   key           in   raw asynchronous button, low = pressed
//   pressed       out  debounced key level, high = held
//   short_pulse   out  one cycle on release of a press shorter than LONG_CYCLES
//   long_pulse    out  one cycle when a hold reaches LONG_CYCLES
//   repeat_pulse  out  one cycle every REPEAT_CYCLES after long_pulse while held
//   dbg_state     out  current classifier state, for observation only
// All outputs are registered; at most one pulse output is high in any cycle.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key,
    output logic       pressed,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output key_state_t dbg_state
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_press_classifier: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("key_press_classifier: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("key_press_classifier: REPEAT_CYCLES must be >= 2");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic key_s;

    key_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (key),
        .q    (key_s)
    );

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    // Remembers whether DB_RELEASE was entered from LONG_HELD, so a bounce
    // returns to the right state and a completed release knows whether the
    // press still counts as short.
    logic             origin_long, origin_long_nxt;
    logic             pressed_nxt, short_nxt, long_nxt, repeat_nxt;

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt + 1'b1;
        origin_long_nxt = origin_long;
        short_nxt       = 1'b0;
        long_nxt        = 1'b0;
        repeat_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!key_s) state_nxt = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (key_s)               state_nxt = ST_IDLE;
                else if (cnt == DB_LAST) state_nxt = ST_HELD;
            end
            ST_HELD: begin
                if (key_s) begin
                    state_nxt       = ST_DB_RELEASE;
                    origin_long_nxt = 1'b0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = ST_LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                // Release wins over a repeat falling due on the same edge.
                if (key_s) begin
                    state_nxt       = ST_DB_RELEASE;
                    origin_long_nxt = 1'b1;
                end else if (cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end
            end
            ST_DB_RELEASE: begin
                // A bounce goes back to the origin state with a cleared counter,
                // so a glitch during HELD restarts the long timer.
                if (!key_s) begin
                    state_nxt = origin_long ? ST_LONG_HELD : ST_HELD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_IDLE;
                    short_nxt = !origin_long;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt != state) cnt_nxt = '0;

        // pressed follows the next state so it rises on the same edge that
        // enters HELD and falls on the edge that returns to IDLE.
        pressed_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_LONG_HELD) ||
                      (state_nxt == ST_DB_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            origin_long  <= 1'b0;
            pressed      <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            origin_long  <= origin_long_nxt;
            pressed      <= pressed_nxt;
            short_pulse  <= short_nxt;
            long_pulse   <= long_nxt;
            repeat_pulse <= repeat_nxt;
        end
    end

    assign dbg_state = state;

endmodule
